// File: rtl/dct_coef_writer.sv
// Coefficient SRAM writer: buffers 8x8 DCT blocks in a small FIFO and writes them to a channel-interleaved address map.
// Optional running XOR checksum of committed coefficients is enabled by defining DCT_WR_CHKSUM_EN.
module dct_coef_writer #(
    parameter int COEF_W        = 11,
    parameter int BLOCKS_PER_CH = 575,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   valid,
    input  logic [64*COEF_W-1:0]   dct_in,
    input  logic                   sram_ready,
    output logic                   sram_wen,
    output logic [10:0]            sram_waddr,
    output logic [64*COEF_W-1:0]   sram_wdata,
    output logic                   done,
    output logic                   overflow,
`ifdef DCT_WR_CHKSUM_EN
    output logic [COEF_W-1:0]      chksum,
`endif
    output logic [1:0]             dbg_state_o
);

    localparam int DW    = 64 * COEF_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BLK_W = $clog2(BLOCKS_PER_CH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLOCKS_PER_CH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;

    state_t           state_q;
    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0] blk_q;
    logic [1:0]       ch_q;
    logic [10:0]      addr_q;
    logic             done_q, ovf_q;
    logic             fifo_empty, fifo_full, push, commit, drop, last_commit;

    // Handshake: a write is offered whenever RUN holds data; it commits on sram_wen && sram_ready.
    assign fifo_empty  = (cnt_q == '0);
    assign fifo_full   = (cnt_q == FULL_CNT);
    assign sram_wen    = (state_q == S_RUN) && !fifo_empty;
    assign commit      = sram_wen && sram_ready;
    assign push        = (state_q == S_RUN) && valid && (!fifo_full || commit);
    assign drop        = (state_q == S_RUN) && valid && fifo_full && !commit;
    assign last_commit = commit && (ch_q == 2'd2) && (blk_q == LAST_BLK);

    assign sram_waddr  = addr_q;
    assign sram_wdata  = sram_wen ? mem_q[rd_ptr_q] : '0;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !commit)
            cnt_d = cnt_q + 1'b1;
        else if (commit && !push)
            cnt_d = cnt_q - 1'b1;
    end

`ifdef DCT_WR_CHKSUM_EN
    logic [COEF_W-1:0] chk_q;

    function automatic logic [COEF_W-1:0] xor_fold(input logic [DW-1:0] blk);
        logic [COEF_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < 64; k++)
            acc ^= blk[k*COEF_W +: COEF_W];
        return acc;
    endfunction

    assign chksum = chk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_q <= '0;
        else if (state_q == S_IDLE && enable)
            chk_q <= '0;
        else if (commit)
            chk_q <= chk_q ^ xor_fold(mem_q[rd_ptr_q]);
    end
`endif

    // Storage has no reset; the output mux gates it to zero whenever no write is offered.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= dct_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            blk_q    <= '0;
            ch_q     <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q  <= S_RUN;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        cnt_q    <= '0;
                        blk_q    <= '0;
                        ch_q     <= '0;
                        addr_q   <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (push)
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (drop)
                        ovf_q <= 1'b1;
                    if (commit) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        // Channel boundary: restart at the next channel's base, which is its index.
                        if (blk_q == LAST_BLK) begin
                            blk_q  <= '0;
                            ch_q   <= ch_q + 2'd1;
                            addr_q <= 11'(ch_q) + 11'd1;
                        end else begin
                            blk_q  <= blk_q + 1'b1;
                            addr_q <= addr_q + 11'd3;
                        end
                    end
                    if (last_commit) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coef_writer.sv
// Scoreboard bench for dct_coef_writer: stimulus pushes expected {addr, data} writes, a monitor pops on each commit.
module tb_dct_coef_writer;

    localparam int COEF_W = 11;
    localparam int BPC    = 575;
    localparam int NBLK   = 3 * BPC;
    localparam int DW     = 64 * COEF_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              valid = 1'b0;
    logic [DW-1:0]     dct_in = '0;
    logic              sram_ready = 1'b0;
    logic              sram_wen;
    logic [10:0]       sram_waddr;
    logic [DW-1:0]     sram_wdata;
    logic              done;
    logic              overflow;
    logic [1:0]        dbg_state;
`ifdef DCT_WR_CHKSUM_EN
    logic [COEF_W-1:0] chksum;
`endif

    dct_coef_writer #(.COEF_W(COEF_W), .BLOCKS_PER_CH(BPC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .valid(valid), .dct_in(dct_in),
        .sram_ready(sram_ready), .sram_wen(sram_wen), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .done(done), .overflow(overflow),
`ifdef DCT_WR_CHKSUM_EN
        .chksum(chksum),
`endif
        .dbg_state_o(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int frame_n = 0;
    int done_count = 0;
    logic [COEF_W-1:0] chk_model = '0;
    logic [10+DW:0] exp_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] exp_addr(input int n);
        return 11'(3 * (n % BPC) + n / BPC);
    endfunction

    function automatic logic [DW-1:0] pat(input int n);
        logic [DW-1:0] d;
        for (int k = 0; k < 64; k++)
            d[k*COEF_W +: COEF_W] = COEF_W'(n * 37 + k * 13 + 1);
        return d;
    endfunction

    function automatic logic [COEF_W-1:0] fold(input logic [DW-1:0] d);
        logic [COEF_W-1:0] a;
        a = '0;
        for (int k = 0; k < 64; k++)
            a ^= d[k*COEF_W +: COEF_W];
        return a;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame();
        frame_n   = 0;
        chk_model = '0;
        enable    = 1'b1;
        tick();
        enable    = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit accept);
        if (accept) begin
            exp_q.push_back({exp_addr(frame_n), d});
            frame_n++;
            chk_model ^= fold(d);
        end
        valid  = 1'b1;
        dct_in = d;
        tick();
        valid  = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            tick();
        chk(name, DW'(exp_q.size()), '0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        start = done_count;
        for (int i = 0; i < budget && done_count == start; i++)
            tick();
        chk(name, DW'(done_count - start), DW'(1));
    endtask

    // Scoreboard monitor: sampled on the falling edge
    logic pend_done = 1'b0;
    always @(negedge clk) begin
        logic [10+DW:0] e;
        logic nxt;
        if (!rst_n) begin
            pend_done = 1'b0;
        end else begin
            if (done || pend_done)
                chk("done_pulse", DW'(done), DW'(pend_done));
            if (done)
                done_count++;
            nxt = 1'b0;
            if (sram_wen && sram_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d expected no write", sram_waddr);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", DW'(sram_waddr), DW'(e[10+DW:DW]));
                    chk("wdata", sram_wdata, e[DW-1:0]);
                    nxt = (e[10+DW:DW] == 11'd1724);
                end
            end
            pend_done = nxt;
        end
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        #12;
        chk("rst_wen", DW'(sram_wen), '0);
        chk("rst_waddr", DW'(sram_waddr), '0);
        chk("rst_wdata", sram_wdata, '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_overflow", DW'(overflow), '0);
        chk("rst_state", DW'(dbg_state), '0);
`ifdef DCT_WR_CHKSUM_EN
        chk("rst_chksum", DW'(chksum), '0);
`endif
        apply_reset();

        // valid while IDLE is ignored
        sram_ready = 1'b1;
        send(pat(999), 1'b0);
        tick();
        chk("idle_no_wen", DW'(sram_wen), '0);
        chk("idle_no_ovf", DW'(overflow), '0);

        // Full frame at full throughput
        start_frame();
        chk("run_state", DW'(dbg_state), DW'(1));
        send(pat(0), 1'b1);
        chk("latency_wen", DW'(sram_wen), DW'(1));
        chk("latency_addr", DW'(sram_waddr), '0);
        for (int n = 1; n < NBLK; n++)
            send(pat(n), 1'b1);
        wait_done("frame_done", 20);
`ifdef DCT_WR_CHKSUM_EN
        chk("frame_chksum", DW'(chksum), DW'(chk_model));
`endif
        tick();
        chk("frame_ovf", DW'(overflow), '0);
        chk("frame_idle", DW'(dbg_state), '0);
        chk("frame_one_done", DW'(done_count), DW'(1));
        drain("frame_drain", 5);

        // Backpressure with two blocks queued; enable mid-frame is ignored
        apply_reset();
        start_frame();
        sram_ready = 1'b0;
        send(pat(100), 1'b1);
        send(pat(101), 1'b1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wen", DW'(sram_wen), DW'(1));
            chk("bp_addr", DW'(sram_waddr), '0);
            chk("bp_data", sram_wdata, pat(100));
            tick();
        end
        sram_ready = 1'b1;
        drain("bp_drain", 10);

        // Overflow: fifth block dropped
        apply_reset();
        start_frame();
        chk("ovf_clear", DW'(overflow), '0);
        sram_ready = 1'b0;
        for (int n = 0; n < 4; n++)
            send(pat(200 + n), 1'b1);
        chk("ovf_not_yet", DW'(overflow), '0);
        send(pat(204), 1'b0);
        chk("ovf_set", DW'(overflow), DW'(1));
        sram_ready = 1'b1;
        drain("ovf_drain", 10);
        tick();
        chk("ovf_empty", DW'(sram_wen), '0);
        chk("ovf_sticky", DW'(overflow), DW'(1));

        // Push into a full FIFO together with a commit
        apply_reset();
        start_frame();
        sram_ready = 1'b0;
        for (int n = 0; n < 4; n++)
            send(pat(300 + n), 1'b1);
        sram_ready = 1'b1;
        send(pat(304), 1'b1);
        send(pat(305), 1'b1);
        chk("full_push_ovf", DW'(overflow), '0);
        drain("full_push_drain", 10);

        // Reset after 100 commits, then restart
        apply_reset();
        start_frame();
        sram_ready = 1'b1;
        for (int n = 0; n < 100; n++)
            send(pat(400 + n), 1'b1);
        tick();
        chk("pre_rst_drain", DW'(exp_q.size()), '0);
        valid  = 1'b1;
        dct_in = pat(500);
        tick();
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("mid_rst_wen", DW'(sram_wen), '0);
        chk("mid_rst_waddr", DW'(sram_waddr), '0);
        chk("mid_rst_wdata", sram_wdata, '0);
        chk("mid_rst_state", DW'(dbg_state), '0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", DW'(sram_wen), '0);
        start_frame();
        send(pat(600), 1'b1);
        chk("restart_addr", DW'(sram_waddr), '0);
        drain("restart_drain", 5);

`ifdef DCT_WR_CHKSUM_EN
        // Checksum frame: every block has dct00 = 5
        apply_reset();
        start_frame();
        sram_ready = 1'b1;
        for (int n = 0; n < NBLK; n++)
            send({11'h5, {(DW-COEF_W){1'b0}}}, 1'b1);
        wait_done("chk_done", 20);
        chk("chk_final", DW'(chksum), DW'(11'h5));
        tick();
        start_frame();
        chk("chk_cleared", DW'(chksum), '0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dct_coef_writer.md
# dct_coef_writer

Back-end writer for the 2-D DCT datapath. Accepts one 8x8 block of 64 coefficients (11 bits each) per `valid` pulse, buffers blocks in a small FIFO, and writes each block as a single 704-bit word to the coefficient SRAM. Addresses follow the same channel-interleaved map the pixel reader uses: Y, then Cb, then Cr, each channel at stride 3. It is the write-side counterpart to the pixel fetch and DCT pipeline.

## Interface

Parameters:
- `COEF_W`, 11, coefficient width in bits.
- `BLOCKS_PER_CH`, 575, number of 8x8 blocks per colour channel.
- `FIFO_DEPTH`, 4, number of buffered blocks; must be a power of two.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: single-cycle pulse that starts a frame. Ignored outside IDLE.
- `valid` input 1: `dct_in` holds a complete block this cycle.
- `dct_in` input 64*COEF_W: packed coefficients `{dct00, dct01, …, dct07, dct10, …, dct77}`, with `dct00` in the MSBs.
- `sram_ready` input 1: SRAM write port accepts a write this cycle.
- `sram_wen` output 1: write request.
- `sram_waddr` output 11: write address.
- `sram_wdata` output 64*COEF_W: write data, same packing as `dct_in`.
- `done` output 1: one-cycle pulse after the frame's last write commits.
- `overflow` output 1: sticky error flag, set when a block is dropped.
- `chksum` output COEF_W: present only with `DCT_WR_CHKSUM_EN` (see Configuration).

## Operation

- State machine with three states.
  - IDLE, on `enable`: go to RUN. Clear the FIFO, channel counter `ch`, block counter `blk`, `overflow` and `chksum`.
  - RUN, on commit of the last Cr block: go to FINISH.
  - FINISH: go to IDLE unconditionally.
- Push: in RUN with `valid=1` and the FIFO not full, store `dct_in`.
  - A push is also accepted when the FIFO is full if a commit happens in the same cycle.
- Drop: in RUN, `valid=1` with the FIFO full and no same-cycle commit.
  - The block is discarded and `overflow` is set to 1.
  - `overflow` stays set until the next accepted `enable` or reset.
- `valid` in IDLE or FINISH is ignored. It does not push and does not set `overflow`.
- Write request: `sram_wen = (state==RUN) && FIFO not empty`. `sram_wdata` is the FIFO head entry.
- Commit: a cycle with `sram_wen && sram_ready`. The FIFO pops and the address advances.
  - While `sram_ready=0`, `sram_waddr` and `sram_wdata` hold stable.
- Address: `sram_waddr = 3*blk + ch`, with `ch` = 0 for Y, 1 for Cb, 2 for Cr.
  - On commit, `blk` increments.
  - At `blk==BLOCKS_PER_CH-1`, `blk` wraps to 0 and `ch` increments.
  - Resulting sequence: 0, 3, …, 1722, 1, 4, …, 1723, 2, 5, …, 1724.
- Frame ends after exactly 3*BLOCKS_PER_CH = 1725 commits. Any FIFO residue is flushed on the next `enable`.
- `enable` during RUN or FINISH is ignored.

## Timing

- Reset values: state=IDLE, FIFO empty, `sram_wen`=0, `sram_waddr`=0, `sram_wdata`=0, `done`=0, `overflow`=0, `chksum`=0.
- Asynchronous reset mid-frame aborts the frame immediately. No further writes occur until the next `enable`.
- Latency: `valid` at cycle t into an empty FIFO gives `sram_wen=1` at t+1.
  - With `sram_ready=1`, commits sustain one block per cycle (full throughput).
- `enable` at cycle t: RUN from t+1. A `valid` at t+1 is accepted.
- `done` is 1 exactly in the cycle after the commit of address 1724, i.e. the FINISH cycle. It is 0 in every other cycle.
- Address and data outputs are driven from registers; there is no combinational path from `dct_in` to `sram_wdata`. `sram_wen` depends only on registered state, not on `sram_ready`.

## Configuration

- `DCT_WR_CHKSUM_EN` defined:
  - Adds the `chksum` output, the bitwise XOR of all 64 coefficients of every committed block in the current frame.
  - `chksum` is cleared on accepted `enable` and is final when `done`=1.
- `DCT_WR_CHKSUM_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan

- Full frame, `sram_ready`=1, 1725 back-to-back `valid` pulses:
  - Commit addresses are 0, 3, …, 1722, 1, …, 1723, 2, …, 1724 with data matching input order.
  - `done` pulses once, one cycle after the last commit.
  - `overflow` stays 0.
- Backpressure: `sram_ready` held 0 for 3 cycles with 2 blocks queued.
  - `sram_waddr` and `sram_wdata` stay constant.
  - Both blocks commit in order once `sram_ready`=1.
- Overflow: `sram_ready`=0, 5 `valid` pulses.
  - 4 blocks are stored, the 5th is dropped, `overflow`=1.
  - After `sram_ready`=1, exactly 4 writes occur at addresses 0, 3, 6, 9.
- Full FIFO with simultaneous push and commit: the block is accepted and `overflow` stays 0.
- Reset and restart:
  - Assert `rst_n`=0 after 100 commits: all outputs return to reset values.
  - New `enable` after reset: writes restart at address 0.
  - `valid` in IDLE: no write occurs.
- With `DCT_WR_CHKSUM_EN`: frame where every block has `dct00`=11'h5 and all other coefficients 0.
  - 1725 blocks (odd count) give `chksum`=11'h5 at `done`.
  - Cleared to 0 on the next `enable`.
